// File: rtl/link_pair_arbiter.sv
// Round-robin arbiter sharing one registered link between clients A and B, tagging each beat with its source.
// Define LINK_PAIR_ARBITER_PACKET_LOCK_EN to hold the grant until the last beat of a multi-beat packet.
module link_pair_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_a_valid,
    output logic             o_a_ready,
    input  logic [WIDTH-1:0] i_a_data,
    input  logic             i_a_last,
    input  logic             i_b_valid,
    output logic             o_b_ready,
    input  logic [WIDTH-1:0] i_b_data,
    input  logic             i_b_last,
    output logic             o_link_valid,
    input  logic             i_link_ready,
    output logic [WIDTH-1:0] o_link_data,
    output logic             o_link_last,
    output logic             o_link_src
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   rr_last_q;
    logic   load_ok;
    logic   grant_a;
    logic   grant_b;
    logic   a_xfer;
    logic   b_xfer;

    assign load_ok   = !o_link_valid || i_link_ready;
    assign o_a_ready = load_ok && grant_a && !i_rst;
    assign o_b_ready = load_ok && grant_b && !i_rst;
    assign a_xfer    = i_a_valid && o_a_ready;
    assign b_xfer    = i_b_valid && o_b_ready;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        grant_a = 1'b0;
        grant_b = 1'b0;
        case (state_q)
            LOCK_A: grant_a = 1'b1;
            LOCK_B: grant_b = 1'b1;
            default: begin
                // A lone requester wins; a tie (or no request) favours the client not served last.
                if (i_a_valid != i_b_valid) begin
                    grant_a = i_a_valid;
                    grant_b = i_b_valid;
                end else begin
                    grant_a = rr_last_q;
                    grant_b = !rr_last_q;
                end
            end
        endcase
    end

`ifdef LINK_PAIR_ARBITER_PACKET_LOCK_EN
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (a_xfer && !i_a_last) begin
                    state_d = LOCK_A;
                end else if (b_xfer && !i_b_last) begin
                    state_d = LOCK_B;
                end
            end
            LOCK_A:  if (a_xfer && i_a_last) state_d = IDLE;
            LOCK_B:  if (b_xfer && i_b_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
`else
    always_comb begin
        state_d = IDLE;
    end
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: non-blocking assignments for all registered state, so every flop samples pre-edge values.
        if (i_rst) begin
            state_q      <= IDLE;
            rr_last_q    <= 1'b1;
            o_link_valid <= 1'b0;
            o_link_data  <= '0;
            o_link_last  <= 1'b0;
            o_link_src   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (a_xfer || b_xfer) begin
                rr_last_q <= b_xfer;
            end
            if (load_ok) begin
                o_link_valid <= a_xfer || b_xfer;
                if (b_xfer) begin
                    o_link_data <= i_b_data;
                    o_link_last <= i_b_last;
                    o_link_src  <= 1'b1;
                end else if (a_xfer) begin
                    o_link_data <= i_a_data;
                    o_link_last <= i_a_last;
                    o_link_src  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_link_pair_arbiter.sv
// Self-checking bench for link_pair_arbiter: directed scenarios with literal expectations plus a random
// phase, all compared every cycle against a behavioural model (honours LINK_PAIR_ARBITER_PACKET_LOCK_EN).
module tb_link_pair_arbiter;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             a_valid = 1'b0;
    logic             a_ready;
    logic [WIDTH-1:0] a_data = '0;
    logic             a_last = 1'b0;
    logic             b_valid = 1'b0;
    logic             b_ready;
    logic [WIDTH-1:0] b_data = '0;
    logic             b_last = 1'b0;
    logic             link_valid;
    logic             link_ready = 1'b0;
    logic [WIDTH-1:0] link_data;
    logic             link_last;
    logic             link_src;

    int n_checks = 0;
    int n_fail   = 0;

    link_pair_arbiter #(.WIDTH(WIDTH)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_a_valid   (a_valid),
        .o_a_ready   (a_ready),
        .i_a_data    (a_data),
        .i_a_last    (a_last),
        .i_b_valid   (b_valid),
        .o_b_ready   (b_ready),
        .i_b_data    (b_data),
        .i_b_last    (b_last),
        .o_link_valid(link_valid),
        .i_link_ready(link_ready),
        .o_link_data (link_data),
        .o_link_last (link_last),
        .o_link_src  (link_src)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- client drivers: queues of {last, data} beats ----------------
    logic [WIDTH:0] qa[$];
    logic [WIDTH:0] qb[$];
    bit a_en = 1'b1;
    bit b_en = 1'b1;
    bit a_fire = 1'b0;
    bit b_fire = 1'b0;

    always @(negedge clk) begin
        a_fire = a_valid && a_ready;
        b_fire = b_valid && b_ready;
    end

    always @(posedge clk) begin
        #2;
        if (a_fire && qa.size() > 0) void'(qa.pop_front());
        if (b_fire && qb.size() > 0) void'(qb.pop_front());
        a_valid = a_en && qa.size() > 0;
        b_valid = b_en && qb.size() > 0;
        if (qa.size() > 0) {a_last, a_data} = qa[0];
        if (qb.size() > 0) {b_last, b_data} = qb[0];
    end

    // ---------------- behavioural model ----------------
    bit             m_valid;
    logic [WIDTH-1:0] m_data;
    bit             m_last;
    bit             m_src;
    int             m_rr;     // client served last: 0 = A, 1 = B
    int             m_lock;   // packet owner, -1 when free
    int             mg;
    bit             mlok, max, mbx, mlst;

    function automatic int exp_grant();
        if (m_lock >= 0) return m_lock;
        if (a_valid != b_valid) return b_valid ? 1 : 0;
        return 1 - m_rr;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
            m_src   <= 1'b0;
            m_rr    <= 1;
            m_lock  <= -1;
        end else begin
            mlok = !m_valid || link_ready;
            mg   = exp_grant();
            max  = a_valid && mlok && mg == 0;
            mbx  = b_valid && mlok && mg == 1;
            if (mlok) m_valid <= max || mbx;
            if (max) begin
                m_data <= a_data; m_last <= a_last; m_src <= 1'b0;
            end
            if (mbx) begin
                m_data <= b_data; m_last <= b_last; m_src <= 1'b1;
            end
            if (max || mbx) m_rr <= mbx ? 1 : 0;
`ifdef LINK_PAIR_ARBITER_PACKET_LOCK_EN
            if (max || mbx) begin
                mlst = mbx ? b_last : a_last;
                if (m_lock < 0 && !mlst) m_lock <= mbx ? 1 : 0;
                else if (m_lock == (mbx ? 1 : 0) && mlst) m_lock <= -1;
            end
`endif
        end
    end

    // ---------------- per-cycle compare and link log ----------------
    logic [WIDTH+1:0] link_log[$];   // {src, last, data} of each beat taken by the sink
    bit cmp_lok;
    int cmp_g;

    always @(negedge clk) begin
        cmp_lok = !m_valid || link_ready;
        cmp_g   = exp_grant();
        check("a_ready", a_ready, !rst && cmp_lok && cmp_g == 0);
        check("b_ready", b_ready, !rst && cmp_lok && cmp_g == 1);
        check("link_valid", link_valid, m_valid);
        if (m_valid) begin
            check("link_data", link_data, m_data);
            check("link_last", link_last, m_last);
            check("link_src", link_src, m_src);
        end
        if (link_valid && link_ready) link_log.push_back({link_src, link_last, link_data});
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_log(input string name, input int idx, input logic [WIDTH-1:0] exp_data,
                             input logic exp_src);
        if (link_log.size() <= idx) begin
            check({name, "_present"}, link_log.size(), idx + 1);
        end else begin
            check(name, link_log[idx][WIDTH-1:0], exp_data);
            check({name, "_src"}, link_log[idx][WIDTH+1], exp_src);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] exp_d[5];
        logic             exp_s[5];

        // ---- reset, then async reset with a pending beat ----
        tick(2);
        rst = 1'b0;
        link_ready = 1'b0;
        qa.push_back({1'b1, 8'h55});
        tick(2);
        #2;
        check("pending_valid", link_valid, 1'b1);
        check("pending_data", link_data, 8'h55);
        rst = 1'b1;
        #1;
        check("rst_link_valid", link_valid, 1'b0);
        check("rst_link_data", link_data, 8'h00);
        check("rst_link_src", link_src, 1'b0);
        check("rst_a_ready", a_ready, 1'b0);
        check("rst_b_ready", b_ready, 1'b0);
        qa.delete();
        qb.delete();
        tick();

        // ---- release with both valid: A first, then per-beat alternation ----
        for (int i = 0; i < 4; i++) begin
            qa.push_back({1'b1, 8'(8'h10 + i)});
            qb.push_back({1'b1, 8'(8'h20 + i)});
        end
        link_ready = 1'b1;
        link_log.delete();
        rst = 1'b0;
        #2;
        check("first_a_ready", a_ready, 1'b1);
        check("first_b_ready", b_ready, 1'b0);
        tick(10);
        check_log("rr0", 0, 8'h10, 1'b0);
        check_log("rr1", 1, 8'h20, 1'b1);
        check_log("rr2", 2, 8'h11, 1'b0);
        check_log("rr3", 3, 8'h21, 1'b1);

        // ---- backpressure: stall, then drain and reload on the same edge ----
        link_ready = 1'b0;
        for (int i = 0; i < 3; i++) qa.push_back({1'b1, 8'(8'h30 + i)});
        tick(5);
        #2;
        check("stall_data", link_data, 8'h30);
        check("stall_valid", link_valid, 1'b1);
        check("stall_a_ready", a_ready, 1'b0);
        link_ready = 1'b1;
        #1;
        check("release_a_ready", a_ready, 1'b1);
        tick();
        #1;
        check("reload_valid", link_valid, 1'b1);
        check("reload_data", link_data, 8'h31);
        tick(4);

        // ---- packet from A while B is continuously valid ----
        link_log.delete();
        a_en = 1'b1;
        b_en = 1'b0;
        qa.push_back({1'b0, 8'hA1});
        qa.push_back({1'b0, 8'hA2});
        qa.push_back({1'b1, 8'hA3});
        qb.push_back({1'b1, 8'h40});
        qb.push_back({1'b1, 8'h41});
        tick();
        b_en = 1'b1;
        tick(8);
`ifdef LINK_PAIR_ARBITER_PACKET_LOCK_EN
        exp_d = '{8'hA1, 8'hA2, 8'hA3, 8'h40, 8'h41};
        exp_s = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`else
        exp_d = '{8'hA1, 8'h40, 8'hA2, 8'h41, 8'hA3};
        exp_s = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`endif
        for (int i = 0; i < 5; i++) check_log($sformatf("pkt%0d", i), i, exp_d[i], exp_s[i]);

        // ---- locked client drops valid mid-packet ----
        link_log.delete();
        b_en = 1'b0;
        qa.push_back({1'b0, 8'h50});
        qa.push_back({1'b0, 8'h51});
        qa.push_back({1'b1, 8'h52});
        qb.push_back({1'b1, 8'h60});
        tick();
        a_en = 1'b0;
        b_en = 1'b1;
        #2;
`ifdef LINK_PAIR_ARBITER_PACKET_LOCK_EN
        check("hole_b_blocked", b_ready, 1'b0);
        tick();
        #2;
        check("hole_idle1", link_valid, 1'b0);
        tick();
        #2;
        check("hole_idle2", link_valid, 1'b0);
        exp_d = '{8'h50, 8'h51, 8'h52, 8'h60, 8'h00};
        exp_s = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
        check("hole_b_ready", b_ready, 1'b1);
        tick();
        #2;
        check("hole_b_loaded", link_valid, 1'b1);
        tick();
        exp_d = '{8'h50, 8'h60, 8'h51, 8'h52, 8'h00};
        exp_s = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`endif
        a_en = 1'b1;
        tick(6);
        for (int i = 0; i < 4; i++) check_log($sformatf("hole%0d", i), i, exp_d[i], exp_s[i]);

        // ---- randomized traffic against the model, with one reset in the middle ----
        for (int c = 0; c < 600; c++) begin
            a_en = ($urandom_range(0, 9) < 7);
            b_en = ($urandom_range(0, 9) < 7);
            link_ready = ($urandom_range(0, 9) < 6);
            while (qa.size() < 4) qa.push_back({1'($urandom_range(0, 2) == 0), 8'($urandom)});
            while (qb.size() < 4) qb.push_back({1'($urandom_range(0, 2) == 0), 8'($urandom)});
            if (c == 300) begin
                #2;
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
